fib_sequencer: RTL
==================

Name: fib_sequencer

Overview:
Control-and-datapath stage directly upstream of the 4-bit holding registers in the hierarchical Fibonacci generator. It produces the reg_in stream: on a start request it emits F(0), F(1), F(2) and so on, one term per clock, for a requested number of terms. It stops early with a sticky overflow flag when the next term would not fit in WIDTH bits. A done pulse and a ready level provide the handshake to surrounding control.

Parameters:
WIDTH, 4, bit width of each emitted term (matches the downstream register width)
CNT_W, 4, bit width of the term count and the term index

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a new sequence; sampled only while ready=1
n_terms  input  CNT_W  number of terms requested; latched when start is accepted
ready  output  1  high in IDLE; start is accepted only when ready=1
term  output  WIDTH  current Fibonacci term; drives the downstream reg_in
term_valid  output  1  term is valid this cycle
term_idx  output  CNT_W  index of the current term (0 = F(0))
done  output  1  one-cycle pulse marking the end of a sequence
overflow  output  1  sticky; high when the last sequence was truncated by overflow

Behaviour:
- State machine has three states: IDLE, RUN and DONE. The state is encoded as 2 bits.
- Reset, applied synchronously at any time including mid-RUN, forces these values:
  - state=IDLE, a=0, b=0, idx=0, n_lat=0, a_inv=0, b_inv=0.
  - overflow=0, term=0, term_valid=0, term_idx=0, done=0, ready=1.
- Output decoding:
  - ready = (state==IDLE).
  - done = (state==DONE).
  - term_valid = (state==RUN and a_inv==0).
  - term = a when term_valid=1, else 0.
  - term_idx = idx when term_valid=1, else 0.
- IDLE with start=1 and n_terms!=0:
  - Load a=0, b=1, a_inv=0, b_inv=0, idx=0, n_lat=n_terms.
  - Clear overflow and go to RUN.
- IDLE with start=1 and n_terms==0:
  - Clear overflow and go to DONE. No term is emitted.
- IDLE with start=0: hold all state.
- RUN cycle with a_inv==0 (a term is emitted):
  - a <= b, a_inv <= b_inv.
  - {carry, b} <= a + b, computed at WIDTH+1 bits.
  - b_inv <= carry | a_inv | b_inv.
  - idx <= idx+1.
  - If idx == n_lat-1, go to DONE; otherwise stay in RUN.
- RUN cycle with a_inv==1: emit nothing, set overflow=1 and go to DONE.
- DONE lasts exactly one cycle, then returns to IDLE. overflow holds its value until the next accepted start.
- start is ignored outside IDLE; there is no queuing.
- Latency and throughput:
  - The first term is valid in the cycle after start is sampled.
  - One term per cycle, with no bubbles.
  - For N terms with no overflow: terms occupy cycles 1..N, done is in cycle N+1, ready is in cycle N+2.
- The index counter never wraps, because the maximum count is 2^CNT_W-1 and the index stops at n_lat-1.
- Arithmetic is unsigned modulo 2^WIDTH. Wrapped values are never emitted: the inv flags suppress them.
- If start is asserted in the same cycle as DONE, it is ignored because ready=0.

Decomposition:
- Shared package fib_pkg holds:
  - the state enumeration constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default widths FIB_WIDTH=4 and FIB_CNT_W=4.
- One sub-module, fib_adder: a WIDTH-parameterised combinational adder with outputs sum[WIDTH-1:0] and carry. It is instantiated once for a+b.

Test Plan:
- Reset mid-RUN: start with n_terms=8, assert reset after 3 terms. Required: next cycle ready=1, term_valid=0, term=0, overflow=0, done=0. A fresh start then restarts at term=0, term_idx=0.
- Normal sequence: start, n_terms=8. Required:
  - terms 0,1,1,2,3,5,8,13 on consecutive cycles, term_idx 0..7;
  - done for one cycle with overflow=0;
  - ready=1 on the following cycle.
- Overflow truncation: start, n_terms=10, WIDTH=4. Required:
  - the same 8 terms as above; 21 is never emitted;
  - the following cycle has no term, then done for one cycle with overflow=1;
  - overflow stays 1 while IDLE until the next start, which clears it.
- Zero count: start, n_terms=0. Required: no term_valid, done pulse in the next cycle, overflow=0.
- Single term and ignored start: start, n_terms=1. Required:
  - term=0 with term_idx=0 for one cycle, then done;
  - start held high throughout causes no restart until ready=1, then restarts at term=0.
- Maximum count: start, n_terms=15, with WIDTH=8 (terms up to F(13)=233 fit, F(14)=377 does not). Required:
  - 14 terms, ending with 233;
  - one empty RUN cycle, then done with overflow=1.

Source files
------------

// File: rtl/fib_pkg.sv
// fib_pkg: shared state encoding and default widths for the Fibonacci sequencer
package fib_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int FIB_WIDTH = 4;
  localparam int FIB_CNT_W = 4;
endpackage

// File: rtl/fib_sequencer_adder.sv
// fib_adder: WIDTH-bit unsigned adder exposing the carry out
module fib_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/fib_sequencer.sv
// fib_sequencer: emits F(0)..F(n-1) one per clock, truncating with a sticky overflow flag
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int CNT_W = FIB_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic             ready,
  output logic [WIDTH-1:0] term,
  output logic             term_valid,
  output logic [CNT_W-1:0] term_idx,
  output logic             done,
  output logic             overflow
);
  state_t state, state_n;
  logic [WIDTH-1:0] a, b, a_n, b_n, sum;
  logic [CNT_W-1:0] idx, idx_n, n_lat, n_lat_n;
  logic a_inv, b_inv, a_inv_n, b_inv_n, ovf_n, carry;
  fib_adder #(.WIDTH(WIDTH)) u_add (.a(a), .b(b), .sum(sum), .carry(carry));
  always_comb begin
    state_n = state;
    a_n = a;
    b_n = b;
    idx_n = idx;
    n_lat_n = n_lat;
    a_inv_n = a_inv;
    b_inv_n = b_inv;
    ovf_n = overflow;
    if (state == IDLE && start) begin
      ovf_n = 1'b0;
      state_n = n_terms != '0 ? RUN : DONE;
      if (n_terms != '0) begin
        a_n = '0;
        b_n = WIDTH'(1);
        a_inv_n = 1'b0;
        b_inv_n = 1'b0;
        idx_n = '0;
        n_lat_n = n_terms;
      end
    end else if (state == RUN && a_inv) begin
      ovf_n = 1'b1;
      state_n = DONE;
    end else if (state == RUN) begin
      a_n = b;
      a_inv_n = b_inv;
      b_n = sum;
      b_inv_n = carry | a_inv | b_inv;
      idx_n = idx + 1'b1;
      state_n = idx == n_lat - 1'b1 ? DONE : RUN;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      idx <= '0;
      n_lat <= '0;
      a_inv <= 1'b0;
      b_inv <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      a <= a_n;
      b <= b_n;
      idx <= idx_n;
      n_lat <= n_lat_n;
      a_inv <= a_inv_n;
      b_inv <= b_inv_n;
      overflow <= ovf_n;
    end
  end
  assign ready = state == IDLE;
  assign done = state == DONE;
  assign term_valid = state == RUN && !a_inv;
  assign term = term_valid ? a : '0;
  assign term_idx = term_valid ? idx : '0;
endmodule
